threads_mask_sequencer: RTL and testbench



---
 rtl/threads_mask_pkg.sv | 48 ++++
 rtl/threads_mask_group_calc.sv | 48 ++++
 rtl/threads_mask_sequencer.sv | 105 ++++++++++
 tb/tb_threads_mask_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/threads_mask_pkg.sv
// Shared definitions for the warp threads_mask sequencer and its helpers.
//   - issue-width encodings, pass-mask constants, thread/group counts
//   - helper functions for selecting the current group from a pending vector
package threads_mask_pkg;

    localparam int unsigned THREADS   = 8;
    localparam int unsigned GROUPS    = 4;
    localparam int unsigned MASK_W    = 4;
    localparam int unsigned GRP_IDX_W = 2;
    localparam int unsigned WIDTH_W   = 2;

    // Issue width; 2'b11 is reserved and handled as QUARTER.
    typedef enum logic [WIDTH_W-1:0] {
        WIDTH_FULL    = 2'b00,
        WIDTH_HALF    = 2'b01,
        WIDTH_QUARTER = 2'b10
    } width_e;

    // Pass-mask encodings seen by the lane-side decoder.
    localparam logic [MASK_W-1:0] MASK_FULL     = 4'b0000;
    localparam logic [MASK_W-1:0] MASK_HALF_LO  = 4'b1000;
    localparam logic [MASK_W-1:0] MASK_HALF_HI  = 4'b1010;
    localparam logic [1:0]        MASK_QTR_BASE = 2'b11;

    // Sequencer control states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // Index of the lowest pending group (0 when nothing is pending).
    function automatic logic [GRP_IDX_W-1:0] lowest_group(input logic [GROUPS-1:0] pend);
        logic [GRP_IDX_W-1:0] idx;
        casez (pend)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // True when exactly one group is pending, i.e. the current beat is the last.
    function automatic logic single_group(input logic [GROUPS-1:0] pend);
        return (pend != '0) && ((pend & (pend - GROUPS'(1))) == '0);
    endfunction

endpackage

// File: rtl/threads_mask_group_calc.sv
// Combinational group calculator, shared with the lane-side decoder's checker.
// Ports:
//   en    [7:0] per-thread enable, bit i = thread i
//   width [1:0] issue width (2'b11 behaves as QUARTER)
//   grp   [1:0] group index whose pass mask is requested
//   pend  [3:0] groups holding at least one enabled thread for this width
//   mask  [3:0] pass-mask encoding for (width, grp)
module threads_mask_group_calc
    import threads_mask_pkg::*;
(
    input  logic [THREADS-1:0]   en,
    input  logic [WIDTH_W-1:0]   width,
    input  logic [GRP_IDX_W-1:0] grp,
    output logic [GROUPS-1:0]    pend,
    output logic [MASK_W-1:0]    mask
);

    // Pending groups: a group with no enabled thread never gets a pass.
    always_comb begin
        pend = '0;
        case (width)
            WIDTH_FULL: begin
                pend[0] = |en;
            end
            WIDTH_HALF: begin
                pend[0] = |en[3:0];
                pend[1] = |en[7:4];
            end
            default: begin
                pend[0] = |en[1:0];
                pend[1] = |en[3:2];
                pend[2] = |en[5:4];
                pend[3] = |en[7:6];
            end
        endcase
    end

    // Mask encoding of one pass; HALF only ever uses groups 0 and 1.
    always_comb begin
        mask = MASK_FULL;
        case (width)
            WIDTH_FULL: mask = MASK_FULL;
            WIDTH_HALF: mask = grp[0] ? MASK_HALF_HI : MASK_HALF_LO;
            default:    mask = {MASK_QTR_BASE, grp};
        endcase
    end

endmodule

// File: rtl/threads_mask_sequencer.sv
// Turns one warp issue request into the ordered stream of threads_mask beats,
// skipping thread groups with no enabled thread.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (req_ready is combinational)
//   req_thread_en     per-thread enable, req_width issue width, req_tag opaque tag
//   out_valid/ready   beat handshake
//   out_threads_mask  pass mask, out_last final beat, out_tag owning request tag
//   busy              groups still pending
module threads_mask_sequencer
    import threads_mask_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [7:0]         req_thread_en,
    input  logic [1:0]         req_width,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_threads_mask,
    output logic               out_last,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    state_e                 state_q;
    state_e                 state_nxt;
    logic [GROUPS-1:0]      pend_q;
    logic [GROUPS-1:0]      pend_nxt;
    logic [GROUPS-1:0]      calc_pend;
    logic [MASK_W-1:0]      calc_mask;
    logic [WIDTH_W-1:0]     width_q;
    logic [WIDTH_W-1:0]     width_sel;
    logic [GRP_IDX_W-1:0]   grp_nxt;
    logic [TAG_W-1:0]       tag_nxt;
    logic                   fire;
    logic                   accept;

    // A new request may land on the final beat handshake, giving no bubble.
    assign fire      = out_valid && out_ready;
    assign req_ready = (state_q == ST_IDLE) || (fire && out_last);
    assign accept    = req_valid && req_ready;

    // The calculator sees the incoming width on accept, otherwise the held one.
    assign width_sel = accept ? req_width : width_q;
    assign grp_nxt   = lowest_group(pend_nxt);

    threads_mask_group_calc u_group_calc (
        .en    (req_thread_en),
        .width (width_sel),
        .grp   (grp_nxt),
        .pend  (calc_pend),
        .mask  (calc_mask)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next pending set, tag and state; zero-enable requests fall back to IDLE.
    always_comb begin
        pend_nxt  = pend_q;
        tag_nxt   = out_tag;
        state_nxt = state_q;
        if (accept) begin
            pend_nxt = calc_pend;
            tag_nxt  = req_tag;
        end else if (fire) begin
            pend_nxt = pend_q & (pend_q - GROUPS'(1));
        end
        state_nxt = (pend_nxt != '0) ? ST_ISSUE : ST_IDLE;
    end

    // Datapath and registered beat outputs, all derived from the next pending set
    // so that a stalled beat simply recomputes to the same values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q           <= '0;
            width_q          <= WIDTH_W'(WIDTH_FULL);
            out_valid        <= 1'b0;
            out_threads_mask <= MASK_FULL;
            out_last         <= 1'b0;
            out_tag          <= '0;
            busy             <= 1'b0;
        end else begin
            pend_q           <= pend_nxt;
            width_q          <= width_sel;
            out_valid        <= (state_nxt == ST_ISSUE);
            out_threads_mask <= (state_nxt == ST_ISSUE) ? calc_mask : MASK_FULL;
            out_last         <= single_group(pend_nxt);
            out_tag          <= tag_nxt;
            busy             <= (pend_nxt != '0);
        end
    end

endmodule

// File: tb/tb_threads_mask_sequencer.sv
// Directed self-checking bench for threads_mask_sequencer.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_threads_mask_sequencer;

    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_thread_en;
    logic [1:0]       req_width;
    logic [TAG_W-1:0] req_tag;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_threads_mask;
    logic             out_last;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    threads_mask_sequencer #(.TAG_W(TAG_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_thread_en    (req_thread_en),
        .req_width        (req_width),
        .req_tag          (req_tag),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_threads_mask (out_threads_mask),
        .out_last         (out_last),
        .out_tag          (out_tag),
        .busy             (busy)
    );

    // {valid, mask, last, tag} snapshot of the output port.
    function automatic logic [9:0] beat();
        return {out_valid, out_threads_mask, out_last, out_tag};
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a request for exactly one clock edge.
    task automatic send(input logic [1:0] w, input logic [7:0] en, input logic [3:0] t);
        req_valid     = 1'b1;
        req_width     = w;
        req_thread_en = en;
        req_tag       = t;
        cyc();
        req_valid     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        n_checks++;
        if (beat() !== 10'b0_0000_0_0000) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", beat(), 10'b0_0000_0_0000);
        end
        n_checks++;
        if ({busy, req_ready} !== 2'b01) begin
            n_fail++; $display("FAIL reset_busy_ready: got %b expected %b", {busy, req_ready}, 2'b01);
        end
    endtask

    task automatic test_full();
        out_ready = 1'b1;
        send(2'b00, 8'hFF, 4'd3);
        n_checks++;
        if (beat() !== {1'b1, 4'b0000, 1'b1, 4'd3}) begin
            n_fail++; $display("FAIL full_beat: got %b expected %b", beat(), {1'b1, 4'b0000, 1'b1, 4'd3});
        end
        n_checks++;
        if ({busy, req_ready} !== 2'b11) begin
            n_fail++; $display("FAIL full_busy_ready: got %b expected %b", {busy, req_ready}, 2'b11);
        end
        cyc();
        n_checks++;
        if ({out_valid, busy, req_ready} !== 3'b001) begin
            n_fail++; $display("FAIL full_done: got %b expected %b", {out_valid, busy, req_ready}, 3'b001);
        end
    endtask

    task automatic test_half();
        logic [9:0] exp [2];
        out_ready = 1'b1;
        send(2'b01, 8'hF0, 4'd5);
        n_checks++;
        if (beat() !== {1'b1, 4'b1010, 1'b1, 4'd5}) begin
            n_fail++; $display("FAIL half_hi_only: got %b expected %b", beat(), {1'b1, 4'b1010, 1'b1, 4'd5});
        end
        cyc();
        exp[0] = {1'b1, 4'b1000, 1'b0, 4'd6};
        exp[1] = {1'b1, 4'b1010, 1'b1, 4'd6};
        send(2'b01, 8'h11, 4'd6);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (beat() !== exp[i]) begin
                n_fail++; $display("FAIL half_two_beat[%0d]: got %b expected %b", i, beat(), exp[i]);
            end
            cyc();
        end
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL half_done: got %b expected %b", {out_valid, busy}, 2'b00);
        end
    endtask

    task automatic test_quarter_backpressure();
        logic [9:0] b2;
        out_ready = 1'b1;
        send(2'b10, 8'b1000_0101, 4'd7);
        n_checks++;
        if (beat() !== {1'b1, 4'b1100, 1'b0, 4'd7}) begin
            n_fail++; $display("FAIL qtr_beat0: got %b expected %b", beat(), {1'b1, 4'b1100, 1'b0, 4'd7});
        end
        cyc();
        b2 = {1'b1, 4'b1101, 1'b0, 4'd7};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({beat(), busy, req_ready} !== {b2, 2'b10}) begin
                n_fail++; $display("FAIL qtr_stall[%0d]: got %b expected %b", i, {beat(), busy, req_ready}, {b2, 2'b10});
            end
            if (i < 3) cyc();
        end
        out_ready = 1'b1;
        cyc();
        n_checks++;
        if (beat() !== {1'b1, 4'b1111, 1'b1, 4'd7}) begin
            n_fail++; $display("FAIL qtr_beat_last: got %b expected %b", beat(), {1'b1, 4'b1111, 1'b1, 4'd7});
        end
        cyc();
        n_checks++;
        if ({out_valid, busy, req_ready} !== 3'b001) begin
            n_fail++; $display("FAIL qtr_done: got %b expected %b", {out_valid, busy, req_ready}, 3'b001);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp [3];
        exp[0] = {1'b1, 4'b1100, 1'b1, 4'd1};
        exp[1] = {1'b1, 4'b1000, 1'b0, 4'd2};
        exp[2] = {1'b1, 4'b1010, 1'b1, 4'd2};
        out_ready = 1'b1;
        send(2'b10, 8'h03, 4'd1);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready_on_last: got %b expected %b", req_ready, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (beat() !== exp[i]) begin
                n_fail++; $display("FAIL b2b_beat[%0d]: got %b expected %b", i, beat(), exp[i]);
            end
            if (i == 0) send(2'b01, 8'hFF, 4'd2);
            else cyc();
        end
        // Zero-enable request on the last handshake returns straight to idle.
        send(2'b00, 8'h80, 4'd4);
        n_checks++;
        if (beat() !== {1'b1, 4'b0000, 1'b1, 4'd4}) begin
            n_fail++; $display("FAIL b2b_full: got %b expected %b", beat(), {1'b1, 4'b0000, 1'b1, 4'd4});
        end
        send(2'b01, 8'h00, 4'd5);
        n_checks++;
        if ({out_valid, busy, req_ready} !== 3'b001) begin
            n_fail++; $display("FAIL b2b_zero_idle: got %b expected %b", {out_valid, busy, req_ready}, 3'b001);
        end
    endtask

    task automatic test_zero_and_reserved();
        out_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            send(2'(w), 8'h00, 4'd9);
            n_checks++;
            if ({out_valid, busy, req_ready} !== 3'b001) begin
                n_fail++; $display("FAIL zero_en_w%0d: got %b expected %b", w, {out_valid, busy, req_ready}, 3'b001);
            end
        end
        send(2'b11, 8'hC0, 4'hA);
        n_checks++;
        if (beat() !== {1'b1, 4'b1111, 1'b1, 4'hA}) begin
            n_fail++; $display("FAIL reserved_width: got %b expected %b", beat(), {1'b1, 4'b1111, 1'b1, 4'hA});
        end
        cyc();
    endtask

    task automatic test_reset_mid_request();
        out_ready = 1'b1;
        send(2'b10, 8'hFF, 4'hB);
        cyc();
        n_checks++;
        if (beat() !== {1'b1, 4'b1101, 1'b0, 4'hB}) begin
            n_fail++; $display("FAIL rst_mid_pre: got %b expected %b", beat(), {1'b1, 4'b1101, 1'b0, 4'hB});
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++;
        if ({beat(), busy, req_ready} !== {10'b0_0000_0_0000, 2'b01}) begin
            n_fail++; $display("FAIL rst_mid_state: got %b expected %b", {beat(), busy, req_ready}, {10'b0_0000_0_0000, 2'b01});
        end
        cyc();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_discard: got %b expected %b", out_valid, 1'b0);
        end
        send(2'b00, 8'h01, 4'hC);
        n_checks++;
        if (beat() !== {1'b1, 4'b0000, 1'b1, 4'hC}) begin
            n_fail++; $display("FAIL rst_mid_after: got %b expected %b", beat(), {1'b1, 4'b0000, 1'b1, 4'hC});
        end
        cyc();
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_thread_en = '0;
        req_width     = '0;
        req_tag       = '0;
        out_ready     = 1'b0;
        @(negedge clk);
        test_reset();
        test_full();
        test_half();
        test_quarter_backpressure();
        test_back_to_back();
        test_zero_and_reserved();
        test_reset_mid_request();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
